// File: rtl/udsp_pkg.sv
// Shared uDSP width constants and data-address helpers, used by the core and the data memory.
package udsp_pkg;
  localparam int DAW    = 10;
  localparam int DWW    = 36;
  localparam int SEGW   = 3;
  localparam int OFFW   = 7;
  localparam int IO_SEG = 7;

  // Physical space: 7 plain segments followed by two I/O pages.
  localparam int PAW    = 11;
  localparam int PDEPTH = 1152;

  typedef logic [DAW-1:0]  daddr_t;
  typedef logic [DWW-1:0]  word_t;
  typedef logic [PAW-1:0]  paddr_t;
  typedef logic [OFFW-1:0] off_t;

  function automatic logic [SEGW-1:0] seg(input daddr_t a);
    return a[DAW-1 -: SEGW];
  endfunction

  function automatic off_t off(input daddr_t a);
    return a[OFFW-1:0];
  endfunction

  function automatic paddr_t io_phys(input logic page, input off_t o);
    return paddr_t'(IO_SEG << OFFW) + {3'b000, page, o};
  endfunction

  function automatic paddr_t core_phys(input daddr_t a, input logic page);
    if (seg(a) == SEGW'(IO_SEG)) return io_phys(page, off(a));
    return {1'b0, a};
  endfunction
endpackage

// File: rtl/udsp_data_mem_if.sv
// Core data ports and host I/O-page port of the uDSP data memory.
interface udsp_data_mem_if;
  import udsp_pkg::*;

  daddr_t addrA;
  word_t  dataA;
  daddr_t addrB;
  word_t  dataB;
  daddr_t addrW;
  word_t  dataW;
  logic   writeEn;
  logic   host_valid;
  logic   host_ready;
  logic   host_we;
  off_t   host_addr;
  word_t  host_wdata;
  logic   host_rvalid;
  word_t  host_rdata;
  logic   io_page;

  modport master (
    output addrA, addrB, addrW, dataW, writeEn,
    output host_valid, host_we, host_addr, host_wdata,
    input  dataA, dataB, host_ready, host_rvalid, host_rdata, io_page
  );

  modport slave (
    input  addrA, addrB, addrW, dataW, writeEn,
    input  host_valid, host_we, host_addr, host_wdata,
    output dataA, dataB, host_ready, host_rvalid, host_rdata, io_page
  );
endinterface

// File: rtl/udsp_mem_copy.sv
// One 1R/1W copy of the physical data array with a registered, read-old-data read port.
module udsp_mem_copy
  import udsp_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   we_i,
  input  paddr_t waddr_i,
  input  word_t  wdata_i,
  input  logic   re_i,
  input  paddr_t raddr_i,
  output word_t  rdata_o
);
  word_t mem_q [PDEPTH];
  word_t rdata_q;

  // NOTE: the array is deliberately kept out of reset so it maps onto RAM macros.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // NOTE: non-blocking read and write at the same edge is what yields old data on collision.
  always_ff @(posedge clk) begin
    if (!reset_n)  rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/udsp_data_mem.sv
// uDSP data memory: three replicated copies, core/host write arbitration and the ping-pong I/O page.
module udsp_data_mem
  import udsp_pkg::*;
(
  input logic             clk,
  input logic             reset_n,
  input logic             start,
  udsp_data_mem_if.slave  bus
);
  logic   io_page_q, io_page_d;
  logic   rvalid_q, rvalid_d;
  logic   host_rd, host_wr, we;
  paddr_t waddr, raddr_a, raddr_b, raddr_h;
  word_t  wdata;
  word_t  data_a, data_b, data_h;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    host_rd   = bus.host_valid && !bus.host_we;
    host_wr   = bus.host_valid && bus.host_we && !bus.writeEn;
    we        = reset_n && (bus.writeEn || host_wr);
    waddr     = io_phys(!io_page_q, bus.host_addr);
    wdata     = bus.host_wdata;
    if (bus.writeEn) begin
      waddr = core_phys(bus.addrW, io_page_q);
      wdata = bus.dataW;
    end
    raddr_a   = core_phys(bus.addrA, io_page_q);
    raddr_b   = core_phys(bus.addrB, io_page_q);
    raddr_h   = io_phys(!io_page_q, bus.host_addr);
    io_page_d = io_page_q ^ start;
    rvalid_d  = host_rd;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      io_page_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      io_page_q <= io_page_d;
      rvalid_q  <= rvalid_d;
    end
  end

  udsp_mem_copy u_copy_a (
    .clk(clk), .reset_n(reset_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(1'b1), .raddr_i(raddr_a), .rdata_o(data_a)
  );

  udsp_mem_copy u_copy_b (
    .clk(clk), .reset_n(reset_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(1'b1), .raddr_i(raddr_b), .rdata_o(data_b)
  );

  // Host copy only updates on an accepted read so host_rdata holds between reads.
  udsp_mem_copy u_copy_h (
    .clk(clk), .reset_n(reset_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(host_rd), .raddr_i(raddr_h), .rdata_o(data_h)
  );

  assign bus.dataA       = data_a;
  assign bus.dataB       = data_b;
  assign bus.host_rdata  = data_h;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_ready  = bus.host_valid && (!bus.host_we || !bus.writeEn);
  assign bus.io_page     = io_page_q;
endmodule

// File: tb/tb_udsp_data_mem.sv
// Directed bench for udsp_data_mem: core reads/writes, host handshake, page swaps and reset.
module tb_udsp_data_mem;
  import udsp_pkg::*;

  logic clk;
  logic reset_n;
  logic start;
  int   n_checks;
  int   n_errors;

  udsp_data_mem_if bus ();

  udsp_data_mem dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n = 1'b0;
    start   = 1'b0;
    bus.addrA = '0; bus.addrB = '0; bus.addrW = '0; bus.dataW = '0; bus.writeEn = 1'b0;
    bus.host_valid = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;

    // Reset state
    step(); step();
    check("rst_dataA", bus.dataA, '0);
    check("rst_dataB", bus.dataB, '0);
    check("rst_hrdata", bus.host_rdata, '0);
    check("rst_hrvalid", word_t'(bus.host_rvalid), '0);
    check("rst_io_page", word_t'(bus.io_page), '0);
    reset_n = 1'b1;

    // Core write, then read-during-write returns old data
    bus.writeEn = 1'b1; bus.addrW = 10'h005; bus.dataW = 36'h111;
    step();
    bus.dataW = 36'h123456789; bus.addrA = 10'h005; bus.addrB = 10'h005;
    step();
    check("rdw_old_A", bus.dataA, 36'h111);
    check("rdw_old_B", bus.dataB, 36'h111);
    bus.writeEn = 1'b0;
    step();
    check("rd_new_A", bus.dataA, 36'h123456789);
    check("rd_new_B", bus.dataB, 36'h123456789);

    // Seed core page 0 of the I/O segment, then host writes page 1
    bus.writeEn = 1'b1; bus.addrW = 10'h383; bus.dataW = 36'h0BB;
    step();
    bus.writeEn = 1'b0;
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd3; bus.host_wdata = 36'hAAA;
    #1 check("hwr_ready", word_t'(bus.host_ready), 36'h1);
    step();
    bus.host_valid = 1'b0; bus.host_we = 1'b0;
    bus.addrA = 10'h383;
    step();
    check("core_pg0_before_start", bus.dataA, 36'h0BB);
    start = 1'b1;
    step();
    start = 1'b0;
    check("io_page_after_start", word_t'(bus.io_page), 36'h1);
    check("read_pre_toggle_map", bus.dataA, 36'h0BB);
    step();
    check("core_sees_host_page", bus.dataA, 36'hAAA);

    // io_page=1: core writes its page while host reads the other
    bus.writeEn = 1'b1; bus.addrW = 10'h383; bus.dataW = 36'h55;
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 7'd3;
    #1 check("hrd_ready_during_wr", word_t'(bus.host_ready), 36'h1);
    step();
    check("hrd_rvalid", word_t'(bus.host_rvalid), 36'h1);
    check("hrd_page_unchanged", bus.host_rdata, 36'h0BB);
    bus.writeEn = 1'b0; bus.host_valid = 1'b0;
    step();
    check("hrd_rvalid_one_cycle", word_t'(bus.host_rvalid), '0);
    check("hrd_rdata_hold", bus.host_rdata, 36'h0BB);
    check("core_own_write", bus.dataA, 36'h55);
    start = 1'b1;
    step();
    start = 1'b0;
    check("io_page_back_0", word_t'(bus.io_page), '0);
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 7'd3;
    step();
    bus.host_valid = 1'b0;
    check("hrd2_rvalid", word_t'(bus.host_rvalid), 36'h1);
    check("hrd2_core_value", bus.host_rdata, 36'h55);

    // Host write stalls behind three core writes
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd5; bus.host_wdata = 36'hCCC;
    for (int i = 0; i < 3; i++) begin
      bus.writeEn = 1'b1; bus.addrW = 10'h010 + 10'(i); bus.dataW = word_t'(i + 1);
      #1 check($sformatf("stall_ready_%0d", i), word_t'(bus.host_ready), '0);
      step();
    end
    bus.writeEn = 1'b0;
    #1 check("stall_release_ready", word_t'(bus.host_ready), 36'h1);
    step();
    bus.host_we = 1'b0; bus.host_addr = 7'd5;
    bus.addrA = 10'h010; bus.addrB = 10'h012;
    step();
    bus.host_valid = 1'b0;
    check("stall_core_wr0", bus.dataA, 36'h1);
    check("stall_core_wr2", bus.dataB, 36'h3);
    check("stall_host_landed", bus.host_rdata, 36'hCCC);

    // start in the same cycle as a host write uses the pre-toggle host page
    bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 7'd9; bus.host_wdata = 36'h999;
    start = 1'b1;
    step();
    bus.host_valid = 1'b0; bus.host_we = 1'b0; start = 1'b0;
    check("start_wr_io_page", word_t'(bus.io_page), 36'h1);
    bus.addrA = 10'h389;
    step();
    check("start_wr_pre_toggle", bus.dataA, 36'h999);

    // Reset during a host read and a core write
    bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 7'd9;
    bus.writeEn = 1'b1; bus.addrW = 10'h010; bus.dataW = 36'hDEAD;
    reset_n = 1'b0;
    step();
    bus.host_valid = 1'b0; bus.writeEn = 1'b0; reset_n = 1'b1;
    check("mid_rst_rvalid", word_t'(bus.host_rvalid), '0);
    check("mid_rst_io_page", word_t'(bus.io_page), '0);
    check("mid_rst_dataA", bus.dataA, '0);
    check("mid_rst_dataB", bus.dataB, '0);
    check("mid_rst_hrdata", bus.host_rdata, '0);
    bus.addrA = 10'h010;
    step();
    check("mid_rst_write_dropped", bus.dataA, 36'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/udsp_data_mem.md
Name: udsp_data_mem

Overview:
- Data memory that serves the uDSP core's three data ports: read ports A and B, and write port W.
- Holds 8 segments of 128 words × 36 bits, addressed as {segment[2:0], offset[6:0]}.
- Segment 7 is a ping-pong I/O buffer: the core sees one page while the host (sample/parameter I/O side) reads and writes the other; pages swap on `start`.
- Sits between the core and the host I/O logic; its registered read outputs are the core's fetch→read pipeline register.

Parameters:
- DAW, 10, core data address width ({SEGW, OFFW}).
- DWW, 36, data word width.
- SEGW, 3, segment field width.
- OFFW, 7, offset field width (DAW = SEGW+OFFW).
- IO_SEG, 7, segment number that is double-buffered.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  frame start; same pulse the core receives; swaps I/O pages.
- addrA  in  DAW  core read address A.
- dataA  out  DWW  registered read data A.
- addrB  in  DAW  core read address B.
- dataB  out  DWW  registered read data B.
- addrW  in  DAW  core write address.
- dataW  in  DWW  core write data.
- writeEn  in  1  core write enable.
- host_valid  in  1  host request valid.
- host_ready  out  1  host request accepted this cycle.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  OFFW  offset within the host-side I/O page.
- host_wdata  in  DWW  host write data.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DWW  host read data.
- io_page  out  1  page currently mapped to the core (the host owns !io_page).

Behaviour:
- Synchronous active-low reset: dataA, dataB, host_rdata ← 0; host_rvalid ← 0; io_page ← 0. Array contents are not reset.
- Core reads: 1-cycle latency. dataA/dataB at edge n+1 reflect addrA/addrB at edge n.
- Read-during-write to the same word returns OLD data; the core forwards from its own writeback stage.
- Physical map:
  - Segments 0..6: 896 words.
  - Segment IO_SEG: 256 words, page bit = io_page for the core and !io_page for the host.
- Storage is replicated per read port (copies A, B, and H for the host). Every accepted write goes to all copies.
- Core write priority: when writeEn=1, only the core write occurs.
- host_ready = host_valid ? (host_we ? !writeEn : 1) : 0.
  - Host writes stall while a core write is in flight.
  - Host reads never stall; they use copy H.
- Host read accepted at edge n → host_rvalid=1 with host_rdata at edge n+1 for exactly one cycle. host_rdata otherwise holds its last value.
- start=1 at an edge toggles io_page.
  - Core accesses and host accesses in that same cycle use the pre-toggle mapping.
  - start has no effect on dataA/dataB/host_rdata beyond normal reads.
- Back-to-back start pulses toggle each cycle; no minimum frame length.
- A core write to IO_SEG always lands in the core page; the host can never corrupt the core page and vice versa.
- reset_n low mid-transaction: pending host_rvalid is dropped and io_page returns to 0; a write in that cycle is not performed.

Decomposition:
- Package udsp_pkg:
  - Width constants DAW, DWW, SEGW, OFFW, IO_SEG.
  - Address field helpers: seg(), off().
  - Shared by the core and this block.
- Natural sub-module: udsp_mem_copy.
  - One synchronous 1R/1W array of 1152 words (896 + 256).
  - Registered read, read-old-data on collision.
  - Instantiated three times (A, B, H).
- The top level holds:
  - Address translation (logical → physical with page bit).
  - Write arbitration.
  - io_page toggle.
  - Host handshake/rvalid register.

Test Plan:
- Reset then core write 0x123456789 to addr 0x005, read A and B at 0x005 next cycle → both outputs equal 0x123456789 one cycle after address; old-data returned on same-cycle read.
- Host writes 0xAAA to offset 3 (page 1 since io_page=0); start pulse; core reads addrA=0x383 → 0xAAA; core reads before start → not 0xAAA.
- Core writes 0x55 to 0x383 with io_page=1; host reads offset 3 same frame → host page value unchanged; after next start host reads 0x55 with host_rvalid one cycle after accept.
- Host write held valid while writeEn=1 for 3 cycles → host_ready=0 for 3 cycles, write lands on 4th; core writes unaffected.
- start asserted same cycle as host write to offset 9 → write goes to pre-toggle host page; verify by reading through core after toggle.
- reset_n low one cycle after an accepted host read → host_rvalid stays 0, io_page=0, dataA=dataB=0.
